// File: rtl/simple_cpu_ctrl.sv
// rtl/simple_cpu_ctrl.sv - multi-cycle control unit for simple_cpu
// Sequences register file, ALU and data memory through DECODE/EXEC/MEM/WB.
module simple_cpu_ctrl #(
  parameter int INSTR_WIDTH   = 20,
  parameter int REG_ADDR_BITS = 2,
  parameter int OFFSET_BITS   = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INSTR_WIDTH-1:0]   instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic                     mem_ack,
  output logic [REG_ADDR_BITS-1:0] rf_ra_addr,
  output logic [REG_ADDR_BITS-1:0] rf_rb_addr,
  output logic                     rf_wr_en,
  output logic [REG_ADDR_BITS-1:0] rf_wr_addr,
  output logic                     rf_wr_sel,
  output logic                     alu_en,
  output logic                     alu_op,
  output logic                     alu_b_sel,
  output logic [OFFSET_BITS-1:0]   offset,
  output logic                     mem_rd_en,
  output logic                     mem_wr_en,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_WIDTH-1:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  state_t                   state_q, state_d;
  logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
  logic [CNT_WIDTH-1:0]     retired_q, retired_d;
  logic                     done_q, done_d;
  logic                     alu_en_q, alu_en_d;
  logic                     alu_b_sel_q, alu_b_sel_d;
  logic                     mem_rd_en_q, mem_rd_en_d;
  logic                     mem_wr_en_q, mem_wr_en_d;
  logic                     rf_wr_en_q, rf_wr_en_d;
  logic                     rf_wr_sel_q, rf_wr_sel_d;
  logic                     retire;

  logic [1:0]               op;
  logic [REG_ADDR_BITS-1:0] x1, x2, x3;

  assign op = ir_q[INSTR_WIDTH-1 -: 2];
  assign x1 = ir_q[16 +: REG_ADDR_BITS];
  assign x2 = ir_q[14 +: REG_ADDR_BITS];
  assign x3 = ir_q[12 +: REG_ADDR_BITS];

  // Field decode is purely from IR so it is stable across every state.
  assign rf_ra_addr = x2;
  assign rf_rb_addr = (op == OP_STORE) ? x1 : x3;
  assign rf_wr_addr = x1;
  assign offset     = ir_q[4 +: OFFSET_BITS];
  assign alu_op     = (op == OP_ALU) && ir_q[0];

  // Gated by rst so no instruction can be offered while reset is held.
  assign instr_ready = (state_q == S_IDLE) && rst;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign retired     = retired_q;
  assign alu_en      = alu_en_q;
  assign alu_b_sel   = alu_b_sel_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign rf_wr_en    = rf_wr_en_q;
  assign rf_wr_sel   = rf_wr_sel_q;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op == OP_NOP) begin
          state_d = S_IDLE;
          retire  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = (op == OP_ALU) ? S_WB : S_MEM;
      S_MEM: begin
        if (mem_ack) begin
          if (op == OP_STORE) begin
            state_d = S_IDLE;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        retire  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    retired_d = retired_q + {{(CNT_WIDTH-1){1'b0}}, retire};
    done_d    = retire;

    // Enables are registered against the state being entered.
    alu_en_d    = (state_d == S_EXEC);
    alu_b_sel_d = (state_d == S_EXEC) && (op != OP_ALU);
    mem_rd_en_d = (state_d == S_MEM) && (op == OP_LOAD);
    mem_wr_en_d = (state_d == S_MEM) && (op == OP_STORE);
    rf_wr_en_d  = (state_d == S_WB);
    rf_wr_sel_d = (state_d == S_WB) && (op == OP_LOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      retired_q   <= '0;
      done_q      <= 1'b0;
      alu_en_q    <= 1'b0;
      alu_b_sel_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      rf_wr_en_q  <= 1'b0;
      rf_wr_sel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      retired_q   <= retired_d;
      done_q      <= done_d;
      alu_en_q    <= alu_en_d;
      alu_b_sel_q <= alu_b_sel_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      rf_wr_en_q  <= rf_wr_en_d;
      rf_wr_sel_q <= rf_wr_sel_d;
    end
  end

endmodule

// File: tb/tb_simple_cpu_ctrl.sv
// tb/tb_simple_cpu_ctrl.sv - directed self-checking bench for simple_cpu_ctrl
module tb_simple_cpu_ctrl;

  logic        clk;
  logic        rst;
  logic [19:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        mem_ack;
  logic [1:0]  rf_ra_addr;
  logic [1:0]  rf_rb_addr;
  logic        rf_wr_en;
  logic [1:0]  rf_wr_addr;
  logic        rf_wr_sel;
  logic        alu_en;
  logic        alu_op;
  logic        alu_b_sel;
  logic [7:0]  offset;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic        busy;
  logic        done;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  simple_cpu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .mem_ack     (mem_ack),
    .rf_ra_addr  (rf_ra_addr),
    .rf_rb_addr  (rf_rb_addr),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_sel   (rf_wr_sel),
    .alu_en      (alu_en),
    .alu_op      (alu_op),
    .alu_b_sel   (alu_b_sel),
    .offset      (offset),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en),
    .busy        (busy),
    .done        (done),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents one instruction for a single edge; returns in the DECODE cycle.
  task automatic issue(input logic [19:0] w);
    chk("ready_before_issue", 32'(instr_ready), 1);
    instr       = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("busy_after_issue", 32'(busy), 1);
  endtask

  initial begin
    int done_cnt;
    rst         = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(instr_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_enables", 32'({alu_en, mem_rd_en, mem_wr_en, rf_wr_en}), 0);
    rst = 1'b1;
    step();
    chk("idle_ready", 32'(instr_ready), 1);

    // ADD r0 = r1 + r3
    issue(20'h47000);
    chk("add_dec_done", 32'(done), 0);
    step();
    chk("add_exec_alu_en", 32'(alu_en), 1);
    chk("add_exec_bsel", 32'(alu_b_sel), 0);
    step();
    chk("add_wb_wr_en", 32'(rf_wr_en), 1);
    chk("add_wb_wr_addr", 32'(rf_wr_addr), 0);
    chk("add_wb_ra", 32'(rf_ra_addr), 1);
    chk("add_wb_rb", 32'(rf_rb_addr), 3);
    chk("add_wb_op", 32'(alu_op), 0);
    chk("add_wb_sel", 32'(rf_wr_sel), 0);
    step();
    chk("add_done", 32'(done), 1);
    chk("add_retired", 32'(retired), 1);
    chk("add_wr_en_off", 32'(rf_wr_en), 0);

    // SUB r3 = r0 - r2
    issue(20'h72001);
    chk("sub_dec_bsel", 32'(alu_b_sel), 0);
    step();
    chk("sub_exec_op", 32'(alu_op), 1);
    chk("sub_exec_alu_en", 32'(alu_en), 1);
    chk("sub_exec_bsel", 32'(alu_b_sel), 0);
    step();
    chk("sub_wb_wr_en", 32'(rf_wr_en), 1);
    chk("sub_wb_wr_addr", 32'(rf_wr_addr), 3);
    chk("sub_wb_bsel", 32'(alu_b_sel), 0);
    step();
    chk("sub_done", 32'(done), 1);
    chk("sub_retired", 32'(retired), 2);

    // STORE_R, ack raised in the third MEM cycle
    issue(20'hD80F0);
    step();
    chk("st_exec_alu_en", 32'(alu_en), 1);
    chk("st_exec_bsel", 32'(alu_b_sel), 1);
    chk("st_exec_off", 32'(offset), 15);
    chk("st_exec_ra", 32'(rf_ra_addr), 2);
    chk("st_exec_rb", 32'(rf_rb_addr), 1);
    chk("st_exec_op", 32'(alu_op), 0);
    chk("st_exec_wr_en", 32'(mem_wr_en), 0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("st_mem%0d_wr_en", i), 32'(mem_wr_en), 1);
      chk($sformatf("st_mem%0d_rf_wr", i), 32'(rf_wr_en), 0);
      chk($sformatf("st_mem%0d_done", i), 32'(done), 0);
      mem_ack = (i == 2);
      step();
    end
    mem_ack = 1'b0;
    chk("st_wr_en_off", 32'(mem_wr_en), 0);
    chk("st_rf_wr", 32'(rf_wr_en), 0);
    chk("st_done", 32'(done), 1);
    chk("st_retired", 32'(retired), 3);

    // LOAD_R, immediate ack
    issue(20'hB80F0);
    step();
    chk("ld_exec_bsel", 32'(alu_b_sel), 1);
    step();
    chk("ld_mem_rd_en", 32'(mem_rd_en), 1);
    chk("ld_mem_wr_en", 32'(mem_wr_en), 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("ld_wb_rd_off", 32'(mem_rd_en), 0);
    chk("ld_wb_wr_en", 32'(rf_wr_en), 1);
    chk("ld_wb_sel", 32'(rf_wr_sel), 1);
    chk("ld_wb_addr", 32'(rf_wr_addr), 3);
    step();
    chk("ld_done", 32'(done), 1);
    chk("ld_retired", 32'(retired), 4);

    // Two ADDs with instr_valid held high
    done_cnt    = 0;
    instr       = 20'h47000;
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) done_cnt++;
    end
    chk("b2b_done_cycle", 32'(done), 1);
    chk("b2b_ready_in_done", 32'(instr_ready), 1);
    step();
    instr_valid = 1'b0;
    chk("b2b_second_accept", 32'(busy), 1);
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) done_cnt++;
    end
    chk("b2b_done_count", 32'(done_cnt), 2);
    chk("b2b_retired", 32'(retired), 6);

    // NOP retires one edge after accept
    issue(20'h00000);
    step();
    chk("nop_done", 32'(done), 1);
    chk("nop_retired", 32'(retired), 7);
    chk("nop_alu_en", 32'(alu_en), 0);

    // Reset asserted while STORE_R waits in MEM
    issue(20'hD80F0);
    step();
    step();
    chk("abort_mem_wr_en", 32'(mem_wr_en), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_wr_drop", 32'(mem_wr_en), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_retired", 32'(retired), 0);
    chk("abort_ready", 32'(instr_ready), 0);
    step();
    rst     = 1'b1;
    mem_ack = 1'b1;
    step();
    step();
    chk("stray_ack_busy", 32'(busy), 0);
    chk("stray_ack_done", 32'(done), 0);
    chk("stray_ack_retired", 32'(retired), 0);
    chk("stray_ack_enables", 32'({mem_rd_en, mem_wr_en, rf_wr_en}), 0);
    mem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
